stim_checker: RTL
=================

STIM_CHECKER -- requirements
Module: stim_checker

Interface
REQ-001 SHALL have parameter SETTLE_CYC, default 1: number of DRIVE cycles per vector before Q_in is sampled; legal range 1..4.
REQ-002 SHALL have port Clk, input, 1, single clock; all state updates on posedge Clk.
REQ-003 SHALL have port Rst, input, 1, reset, asynchronous and active-high.
REQ-004 SHALL have port Start, input, 1, request one full 16-vector sweep.
REQ-005 SHALL have port Q_in, input, 1, registered response returned by the combi-logic/negedge-flop system under test.
REQ-006 SHALL have port Vec_out, output, 4, stimulus vector driven to the system's In bus.
REQ-007 SHALL have port Busy, output, 1, high while a sweep is in progress.
REQ-008 SHALL have port Done, output, 1, high after a sweep completes.
REQ-009 SHALL have port Pass, output, 1, high when Done=1 and Err_cnt=0.
REQ-010 SHALL have port Err_cnt, output, 5, count of mismatching vectors in the current or last sweep.
REQ-011 SHALL have port First_fail, output, 4, first mismatching vector; valid only when Fail_seen=1.
REQ-012 SHALL have port Fail_seen, output, 1, high once any mismatch has been recorded in the current or last sweep.

Function
REQ-013 SHALL implement the FSM states IDLE, DRIVE, SAMPLE and DONE.
REQ-014 SHALL, in IDLE with Start=1 at posedge, clear Err_cnt, Fail_seen and First_fail, load Vec_out=0000 and enter DRIVE.
REQ-015 SHALL hold Vec_out stable for SETTLE_CYC cycles in DRIVE (internal counter), then enter SAMPLE.
REQ-016 SHALL compute the expected value exp = (V[0]&V[1]) | V[2] | V[3] from Vec_out, registered in the same cycle as Vec_out.
REQ-017 SHALL, at the posedge ending SAMPLE, compare Q_in with exp; on mismatch increment Err_cnt by 1, and if Fail_seen=0 set First_fail=Vec_out and Fail_seen=1.
REQ-018 SHALL, after SAMPLE with Vec_out<1111, increment Vec_out and return to DRIVE; with Vec_out=1111, enter DONE with Vec_out held at 1111.
REQ-019 SHALL take (SETTLE_CYC+1) cycles per vector, so Done rises 16*(SETTLE_CYC+1) posedges after the Start-accepting edge (32 for the default).
REQ-020 SHALL drive Busy=1 exactly in DRIVE and SAMPLE, and Done=1 exactly in DONE.
REQ-021 SHALL ignore Start while Busy=1.
REQ-022 SHALL, in DONE with Start=1, behave as in IDLE (restart); otherwise remain in DONE holding all results.
REQ-023 SHALL not saturate Err_cnt; its maximum value is 16 (10000), which fits 5 bits.
REQ-024 SHALL compute Pass combinationally as Done & (Err_cnt==0).

Reset
REQ-025 SHALL, while Rst=1 and independent of Clk, force state=IDLE, Vec_out=0000, Busy=0, Done=0, Err_cnt=0, Fail_seen=0, First_fail=0000 and the settle counter to 0, giving Pass=0.
REQ-026 SHALL abort a sweep immediately on Rst asserted mid-operation and discard all partial results.
REQ-027 SHALL accept no Start while Rst=1; the first sweep begins at the first posedge with Rst=0 and Start=1.

Verification
REQ-028 SHALL verify the golden case: correct system attached, Start pulse -> Done=1 after 32 cycles, Pass=1, Err_cnt=0, Fail_seen=0.
REQ-029 SHALL verify stuck-at-0: Q_in tied 0 -> Err_cnt=13 (01101), First_fail=0011, Pass=0.
REQ-030 SHALL verify stuck-at-1: Q_in tied 1 -> Err_cnt=3, First_fail=0000, Pass=0.
REQ-031 SHALL verify an inverted response: Q_in = ~exp -> Err_cnt=16 (10000), First_fail=0000.
REQ-032 SHALL verify reset mid-sweep: Rst pulsed while Vec_out=0111 -> all outputs 0 asynchronously; a new Start then gives a full 32-cycle golden run with Pass=1.
REQ-033 SHALL verify Start handling: Start held high through the sweep -> no restart while Busy; at DONE, Start=1 -> Busy=1 next cycle, Vec_out=0000, Err_cnt cleared.

Source files
------------

// File: rtl/stim_checker.sv
// Sweeps all 16 input vectors through an external combinational/negedge-flop system
// and checks each registered response against (V0&V1)|V2|V3.
module stim_checker #(
    parameter int SETTLE_CYC = 1
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Start,
    input  logic       Q_in,
    output logic [3:0] Vec_out,
    output logic       Busy,
    output logic       Done,
    output logic       Pass,
    output logic [4:0] Err_cnt,
    output logic [3:0] First_fail,
    output logic       Fail_seen
);

    typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_e;

    localparam logic [1:0] SETTLE_LAST = 2'(SETTLE_CYC - 1);

    state_e     r_state;
    state_e     w_nextState;
    logic [1:0] r_settle;
    logic [3:0] r_vec;
    logic       r_exp;
    logic [4:0] r_errCnt;
    logic [3:0] r_firstFail;
    logic       r_failSeen;

    logic       w_accept;
    logic       w_settleDone;
    logic       w_mismatch;
    logic [3:0] w_vecNext;

    function automatic logic expOf(input logic [3:0] v);
        return (v[0] & v[1]) | v[2] | v[3];
    endfunction

    assign w_accept     = Start && ((r_state == IDLE) || (r_state == DONE));
    assign w_settleDone = (r_settle == SETTLE_LAST);
    assign w_mismatch   = (Q_in != r_exp);
    assign w_vecNext    = r_vec + 4'd1;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (Start) w_nextState = DRIVE;
            DRIVE:   if (w_settleDone) w_nextState = SAMPLE;
            SAMPLE:  w_nextState = (r_vec == 4'hF) ? DONE : DRIVE;
            DONE:    if (Start) w_nextState = DRIVE;
            default: w_nextState = IDLE;
        endcase
    end

    always_comb begin
        Busy = 1'b0;
        Done = 1'b0;
        case (r_state)
            DRIVE, SAMPLE: Busy = 1'b1;
            DONE:          Done = 1'b1;
            default:       ;
        endcase
    end

    // Expected value is refreshed together with the vector so it always matches Vec_out.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_settle    <= 2'd0;
            r_vec       <= 4'd0;
            r_exp       <= 1'b0;
            r_errCnt    <= 5'd0;
            r_firstFail <= 4'd0;
            r_failSeen  <= 1'b0;
        end else if (w_accept) begin
            r_settle    <= 2'd0;
            r_vec       <= 4'd0;
            r_exp       <= expOf(4'd0);
            r_errCnt    <= 5'd0;
            r_firstFail <= 4'd0;
            r_failSeen  <= 1'b0;
        end else if (r_state == DRIVE) begin
            r_settle <= w_settleDone ? 2'd0 : r_settle + 2'd1;
        end else if (r_state == SAMPLE) begin
            if (w_mismatch) begin
                r_errCnt <= r_errCnt + 5'd1;
                if (!r_failSeen) begin
                    r_firstFail <= r_vec;
                    r_failSeen  <= 1'b1;
                end
            end
            if (r_vec != 4'hF) begin
                r_vec <= w_vecNext;
                r_exp <= expOf(w_vecNext);
            end
        end
    end

    assign Vec_out    = r_vec;
    assign Err_cnt    = r_errCnt;
    assign First_fail = r_firstFail;
    assign Fail_seen  = r_failSeen;
    assign Pass       = Done & (r_errCnt == 5'd0);

endmodule
